// File: rtl/flit_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flit_rx_pkg
// Brief   : Shared defaults and FSM state encoding for the flit activity
//           receiver.
// Revision: 1.0 - initial release
// ============================================================================
package flit_rx_pkg;

  localparam int N_DEF           = 11;
  localparam int PAYLOAD_MAX_DEF = 20;
  localparam int FLIT_W_DEF      = 2 * N_DEF;

  // Receiver FSM states (IDLE / RECV / REPORT)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RECV   = 2'd1;
  localparam state_t ST_REPORT = 2'd2;

endpackage : flit_rx_pkg
`default_nettype wire

// File: rtl/popcount_flit.sv
`default_nettype none
// ============================================================================
// Module  : popcount_flit
// Brief   : Combinational population count of one flit.
// Ports   : i_flit  [FLIT_W-1:0]  flit to count
//           o_count [4:0]         number of set bits
// Revision: 1.0 - initial release
// ============================================================================
module popcount_flit #(
  parameter int FLIT_W = 22
) (
  input  logic [FLIT_W-1:0] i_flit,
  output logic [4:0]        o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < FLIT_W; i++) begin
      o_count = o_count + 5'(i_flit[i]);
    end
  end

endmodule : popcount_flit
`default_nettype wire

// File: rtl/flit_activity_rx.sv
`default_nettype none
// ============================================================================
// Module  : flit_activity_rx
// Brief   : Flit receiver that unpacks each flit into two operands and
//           reports per-packet flit count and bit-toggle activity.
// Ports   : clk, rst_n                 clock, synchronous active-low reset
//           in_valid/in_last/in_data   flit input, in_ready back-pressure
//           op1/op2/op_valid           operands of the last accepted flit
//           stat_valid/stat_ready      per-packet statistics handshake
//           pkt_flits/pkt_toggles/pkt_trunc  reported packet statistics
//           pkt_count                  packets reported since reset
// Revision: 1.0 - initial release
// ============================================================================
module flit_activity_rx
  import flit_rx_pkg::*;
#(
  parameter  int N           = N_DEF,
  parameter  int PAYLOAD_MAX = PAYLOAD_MAX_DEF,
  localparam int FLIT_W      = 2 * N,
  localparam int CNT_W       = $clog2(PAYLOAD_MAX + 1),
  localparam int TOG_W       = $clog2(PAYLOAD_MAX * FLIT_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [FLIT_W-1:0] in_data,
  output logic              in_ready,
  output logic [N-1:0]      op1,
  output logic [N-1:0]      op2,
  output logic              op_valid,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [CNT_W-1:0]  pkt_flits,
  output logic [TOG_W-1:0]  pkt_toggles,
  output logic              pkt_trunc,
  output logic [15:0]       pkt_count
);

  state_t              r_state;
  logic [N-1:0]        r_op1;
  logic [N-1:0]        r_op2;
  logic                r_op_valid;
  logic [FLIT_W-1:0]   r_prev;
  logic [CNT_W-1:0]    r_cnt;
  logic [TOG_W-1:0]    r_acc;
  logic                r_trunc;
  logic [15:0]         r_pkt_count;

  logic                w_accept;
  logic [4:0]          w_tog;
  logic [CNT_W-1:0]    w_next_cnt;
  logic [TOG_W-1:0]    w_next_acc;
  logic                w_end;

  popcount_flit #(
    .FLIT_W (FLIT_W)
  ) u_popcount (
    .i_flit  (in_data ^ r_prev),
    .o_count (w_tog)
  );

  assign in_ready   = (r_state != ST_REPORT);
  assign stat_valid = (r_state == ST_REPORT);
  assign w_accept   = in_valid && in_ready;

  // A flit taken in IDLE opens a new packet, so count/accumulator load
  // instead of adding.
  assign w_next_cnt = (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_next_acc = (r_state == ST_IDLE) ? TOG_W'(w_tog) : r_acc + TOG_W'(w_tog);
  assign w_end      = in_last || (w_next_cnt == CNT_W'(PAYLOAD_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op1       <= '0;
      r_op2       <= '0;
      r_op_valid  <= 1'b0;
      r_prev      <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_trunc     <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_op_valid <= w_accept;
      if (w_accept) begin
        r_op1  <= in_data[N-1:0];
        r_op2  <= in_data[FLIT_W-1:N];
        r_prev <= in_data;
        r_cnt  <= w_next_cnt;
        r_acc  <= w_next_acc;
        if (w_end) begin
          r_state <= ST_REPORT;
          // Ending without in_last means the payload limit cut the packet.
          r_trunc <= !in_last;
        end else begin
          r_state <= ST_RECV;
        end
      end else if ((r_state == ST_REPORT) && stat_ready) begin
        r_state     <= ST_IDLE;
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

  assign op1         = r_op1;
  assign op2         = r_op2;
  assign op_valid    = r_op_valid;
  assign pkt_flits   = r_cnt;
  assign pkt_toggles = r_acc;
  assign pkt_trunc   = r_trunc;
  assign pkt_count   = r_pkt_count;

endmodule : flit_activity_rx
`default_nettype wire

// File: tb/tb_flit_activity_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_flit_activity_rx
// Brief   : Scoreboard testbench for flit_activity_rx with a packet-level
//           reference model and randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_flit_activity_rx;

  localparam int N  = 11;
  localparam int PM = 20;
  localparam int FW = 22;
  localparam int CW = 5;
  localparam int TW = 9;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          in_valid   = 1'b0;
  logic          in_last    = 1'b0;
  logic [FW-1:0] in_data    = '0;
  logic          stat_ready = 1'b0;
  logic          in_ready;
  logic [N-1:0]  op1;
  logic [N-1:0]  op2;
  logic          op_valid;
  logic          stat_valid;
  logic [CW-1:0] pkt_flits;
  logic [TW-1:0] pkt_toggles;
  logic          pkt_trunc;
  logic [15:0]   pkt_count;

  flit_activity_rx #(.N(N), .PAYLOAD_MAX(PM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .op1         (op1),
    .op2         (op2),
    .op_valid    (op_valid),
    .stat_valid  (stat_valid),
    .stat_ready  (stat_ready),
    .pkt_flits   (pkt_flits),
    .pkt_toggles (pkt_toggles),
    .pkt_trunc   (pkt_trunc),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int flits;
    int tog;
    int trunc;
    int cnt;
  } rep_t;

  rep_t          rep_q[$];
  logic [FW-1:0] op_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  // Reference model state: packet-level view of the traffic.
  logic [FW-1:0] m_prev = '0;
  logic [FW-1:0] m_base = '0;
  logic [FW-1:0] m_pkt[$];
  int            m_reports = 0;
  bit            sr_auto = 1'b0;
  bit            sr_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void model_accept(input logic [FW-1:0] d, input bit last);
    rep_t          r;
    int            t;
    logic [FW-1:0] p;
    op_q.push_back(d);
    if (m_pkt.size() == 0) m_base = m_prev;
    m_pkt.push_back(d);
    m_prev = d;
    if (last || m_pkt.size() == PM) begin
      t = 0;
      p = m_base;
      foreach (m_pkt[i]) begin
        t += $countones(m_pkt[i] ^ p);
        p = m_pkt[i];
      end
      r.flits = m_pkt.size();
      r.tog   = t;
      r.trunc = last ? 0 : 1;
      r.cnt   = m_reports % 65536;
      rep_q.push_back(r);
      m_reports++;
      m_pkt.delete();
    end
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the flit was taken.
  task automatic send_flit(input logic [FW-1:0] d, input bit last);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (in_ready) model_accept(d, last);
    else check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = FW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_data = FW'($urandom);
      in_last = 1'($urandom_range(0, 1));
    end
    in_last = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_prev    = '0;
    m_pkt.delete();
    m_reports = 0;
    @(negedge clk);
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_stat_valid",  32'(stat_valid),  32'd0);
    check("rst_op_valid",    32'(op_valid),    32'd0);
    check("rst_op1",         32'(op1),         32'd0);
    check("rst_op2",         32'(op2),         32'd0);
    check("rst_pkt_flits",   32'(pkt_flits),   32'd0);
    check("rst_pkt_toggles", 32'(pkt_toggles), 32'd0);
    check("rst_pkt_trunc",   32'(pkt_trunc),   32'd0);
    check("rst_pkt_count",   32'(pkt_count),   32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] walk_next(input logic [FW-1:0] x);
    logic [FW-1:0] lo;
    lo = ~x & FW'(6'h3F);
    return (x >> 6) | (lo << 16);
  endfunction

  // stat_ready driver when not under direct control
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sr_auto) stat_ready = sr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin
    logic [FW-1:0] d;
    rep_t          r;
    forever begin
      @(negedge clk);
      if (op_valid) begin
        if (op_q.size() == 0) check("op_unexpected", 32'd1, 32'd0);
        else begin
          d = op_q.pop_front();
          check("op1", 32'(op1), 32'(d[N-1:0]));
          check("op2", 32'(op2), 32'(d[FW-1:N]));
        end
      end
      if (stat_valid && stat_ready) begin
        if (rep_q.size() == 0) check("report_unexpected", 32'd1, 32'd0);
        else begin
          r = rep_q.pop_front();
          check("pkt_flits",   32'(pkt_flits),   32'(r.flits));
          check("pkt_toggles", 32'(pkt_toggles), 32'(r.tog));
          check("pkt_trunc",   32'(pkt_trunc),   32'(r.trunc));
          check("pkt_count",   32'(pkt_count),   32'(r.cnt));
        end
      end
    end
  end

  initial begin : main
    logic [FW-1:0] x;
    int            len;
    int            w;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    sr_auto = 1'b1;

    // Single terminated flit
    send_flit(22'h3F0000, 1'b1);
    idle(4);

    // 20-flit walking-ones packet, then the same after a 7-cycle gap
    do_reset();
    x = '0;
    for (int i = 0; i < PM; i++) begin
      x = walk_next(x);
      send_flit(x, i == PM - 1);
    end
    idle(7);
    x = '0;
    for (int i = 0; i < PM; i++) begin
      x = walk_next(x);
      send_flit(x, i == PM - 1);
    end
    idle(5);
    check("pkt_count_two", 32'(pkt_count), 32'd2);

    // 21 flits without in_last; statistics consumer stalls 5 cycles
    sr_auto    = 1'b0;
    stat_ready = 1'b0;
    fork
      begin
        logic [FW-1:0] y;
        y = '0;
        for (int i = 0; i < PM + 1; i++) begin
          y = walk_next(y);
          send_flit(y, 1'b0);
        end
      end
      begin
        w = 0;
        @(negedge clk);
        while (!stat_valid && w < 400) begin
          w++;
          @(negedge clk);
        end
        check("trunc_report_seen", 32'(stat_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        stat_ready = 1'b1;
      end
    join
    send_flit(FW'($urandom), 1'b1);
    idle(3);
    sr_auto = 1'b1;

    // Reset after flit 10 of a packet, then a fresh packet
    for (int i = 0; i < 10; i++) send_flit(FW'($urandom), 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) send_flit(FW'($urandom), i == 2);
    idle(3);

    // Randomized traffic with random stat_ready back-pressure
    sr_rand = 1'b1;
    repeat (40) begin
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++)
        send_flit(FW'($urandom), (i == len - 1) && ($urandom_range(0, 3) != 0));
      idle($urandom_range(0, 3));
    end
    send_flit(FW'($urandom), 1'b1);
    sr_rand = 1'b0;

    w = 0;
    while ((rep_q.size() != 0 || op_q.size() != 0) && w < 200) begin
      w++;
      @(posedge clk);
    end
    idle(2);
    check("report_queue_drained", 32'(rep_q.size()), 32'd0);
    check("op_queue_drained",     32'(op_q.size()),  32'd0);
    check("final_pkt_count",      32'(pkt_count),    32'(m_reports % 65536));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_flit_activity_rx
`default_nettype wire

// File: doc/flit_activity_rx.md
FLIT_ACTIVITY_RX -- requirements
Module: flit_activity_rx

Interface
REQ-001 Parameter N, default 11: operand width; each flit carries two N-bit operands.
REQ-002 Parameter PAYLOAD_MAX, default 20: maximum flits per packet.
REQ-003 Derived constants FLIT_W=2*N, CNT_W=$clog2(PAYLOAD_MAX+1), TOG_W=$clog2(PAYLOAD_MAX*FLIT_W+1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous reset, active-low.
REQ-006 in_valid  in  1  flit present on in_data.
REQ-007 in_last  in  1  qualifies the current flit as the final flit of its packet.
REQ-008 in_data  in  FLIT_W  flit payload.
REQ-009 in_ready  out  1  receiver accepts the flit this cycle.
REQ-010 op1  out  N  registered in_data[N-1:0] of the last accepted flit.
REQ-011 op2  out  N  registered in_data[FLIT_W-1:N] of the last accepted flit.
REQ-012 op_valid  out  1  one-cycle pulse: op1/op2 updated.
REQ-013 stat_valid, stat_ready  out/in  1 each  per-packet statistics handshake.
REQ-014 pkt_flits  out  CNT_W  flits in the reported packet.
REQ-015 pkt_toggles  out  TOG_W  summed bit toggles of the reported packet.
REQ-016 pkt_trunc  out  1  reported packet hit PAYLOAD_MAX without in_last.
REQ-017 pkt_count  out  16  total packets reported since reset; wraps 0xFFFF->0.

Function
REQ-018 A flit is accepted in any cycle where in_valid && in_ready.
REQ-019 FSM states: IDLE, RECV, REPORT; reset state is IDLE.
REQ-020 IDLE->RECV on accept without in_last; IDLE->REPORT on accept with in_last.
REQ-021 RECV->REPORT on accept with in_last, or on the accept that brings the flit count to PAYLOAD_MAX (pkt_trunc=1 if in_last was low).
REQ-022 in_ready=1 in IDLE and RECV and 0 in REPORT; stat_valid=1 only in REPORT.
REQ-023 REPORT->IDLE on stat_valid && stat_ready; pkt_count increments on that same edge.
REQ-024 The per-flit toggle value is popcount(in_data XOR prev_flit), where prev_flit is the last accepted flit and persists across packet boundaries.
REQ-025 On the first flit of a packet the accumulator loads that flit's toggle value; on later flits it adds the toggle value. Flit count behaves the same way with an increment of 1.
REQ-026 Accumulator and count are held stable while in REPORT until the handshake completes.
REQ-027 op1/op2/prev_flit update one cycle after accept (latency 1); op_valid pulses in that same cycle.
REQ-028 Cycles with in_valid=0 do not change count, accumulator or prev_flit (idle gaps are free).
REQ-029 pkt_flits, pkt_toggles and pkt_trunc are registered and reflect the packet being reported.

Reset
REQ-030 When rst_n=0 at a clock edge, all of the following are cleared: state=IDLE, op1=op2=0, prev_flit=0, op_valid=0, stat_valid=0, pkt_flits=0, pkt_toggles=0, pkt_trunc=0, pkt_count=0.
REQ-031 A reset in mid-packet or during REPORT discards the partial packet without reporting it; in_ready=1 on the first cycle after reset.

Structure
REQ-032 Package flit_rx_pkg holds the FSM state enum and the N/PAYLOAD_MAX/FLIT_W defaults.
REQ-033 A combinational popcount sub-module, popcount_flit (FLIT_W in, 5-bit out), is the only child module.

Verification
REQ-034 Single flit 0x3F0000 with in_last, after reset -> op2=0x7E0, op1=0x000, pkt_flits=1, pkt_toggles=6, pkt_trunc=0.
REQ-035 20-flit walking-ones packet (0x3F0000, 0x3FFC00, 0x3FFFF0, ... , last flit 0x000FFF, 6 toggles each) with in_last on flit 20 -> pkt_flits=20, pkt_toggles=120.
REQ-036 Second identical packet after a 7-cycle gap -> first flit contributes 18 toggles from prev 0x000FFF; pkt_toggles=132, pkt_count=2.
REQ-037 21 flits with no in_last -> report after flit 20 with pkt_trunc=1 and pkt_flits=20; in_ready=0 while stat_ready is held low for 5 cycles; flit 21 is accepted only after the handshake.
REQ-038 rst_n low for 1 cycle after flit 10 of a packet -> no report; pkt_count=0; the next packet's first flit is toggle-counted against prev_flit 0.
